// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and counter sizing.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_state_t;

  // Bits needed to hold every value from 0 up to and including max_value.
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous clear.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer: pulses the PLL reset, qualifies lock, releases domain
// resets in a staggered order, and retries or faults when lock never qualifies.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS        = 3,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int STAGGER_CYCLES     = 8,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               locked,
  input  logic                               restart_req,
  output logic                               pll_rst,
  output logic [NUM_DOMAINS-1:0]             dom_rst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         lost_lock_cnt,
  output pll_state_t                         state
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int RST_W   = cnt_width(PLL_RST_CYCLES);
  localparam int TMR_W   = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W   = cnt_width(LOCK_STABLE_CYCLES);
  localparam int REL_W   = cnt_width(STAGGER_CYCLES * (NUM_DOMAINS - 1));

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0]   STB_MAX   = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [REL_W-1:0]   REL_LAST  = REL_W'(STAGGER_CYCLES * (NUM_DOMAINS - 1));
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_state_t             state_n;
  logic [RST_W-1:0]       rst_cnt, rst_cnt_n;
  logic [TMR_W-1:0]       timer, timer_n;
  logic [STB_W-1:0]       stable_cnt, stable_n;
  logic [REL_W-1:0]       rel_cnt, rel_n;
  logic [RETRY_W-1:0]     retry_n;
  logic [7:0]             lost_n;
  logic                   pll_rst_n, ready_n, fault_n;
  logic [NUM_DOMAINS-1:0] dom_n;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // Priority: restart_req, then lock loss, then timeout, then normal progress.
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    timer_n   = timer;
    stable_n  = stable_cnt;
    rel_n     = rel_cnt;
    retry_n   = retry_cnt;
    lost_n    = lost_lock_cnt;

    if (restart_req) begin
      state_n   = PLL_RESET;
      rst_cnt_n = '0;
      timer_n   = '0;
      retry_n   = '0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state_n   = WAIT_LOCK;
            rst_cnt_n = '0;
            timer_n   = '0;
          end else begin
            rst_cnt_n = rst_cnt + RST_W'(1);
          end
        end
        WAIT_LOCK, STABLE: begin
          if (timer == TMR_MAX) begin
            retry_n   = retry_cnt + RETRY_W'(1);
            rst_cnt_n = '0;
            timer_n   = '0;
            state_n   = (retry_n == RETRY_MAX) ? FAULT : PLL_RESET;
          end else begin
            // The timeout keeps running across STABLE->WAIT_LOCK bounces.
            timer_n = timer + TMR_W'(1);
            if (state == WAIT_LOCK) begin
              if (lock_s) begin
                state_n  = STABLE;
                stable_n = '0;
              end
            end else if (!lock_s) begin
              state_n = WAIT_LOCK;
            end else begin
              stable_n = stable_cnt + STB_W'(1);
              if (stable_n == STB_MAX) begin
                state_n = RELEASE;
                rel_n   = '0;
              end
            end
          end
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            state_n   = PLL_RESET;
            rst_cnt_n = '0;
            if (lost_lock_cnt != 8'hFF) lost_n = lost_lock_cnt + 8'd1;
          end else if (state == RELEASE) begin
            if (rel_cnt == REL_LAST) begin
              state_n = RUN;
              retry_n = '0;
            end else begin
              rel_n = rel_cnt + REL_W'(1);
            end
          end
        end
        FAULT:   state_n = FAULT;
        default: state_n = PLL_RESET;
      endcase
    end

    // Outputs are registered from the next state so they line up with it exactly.
    pll_rst_n = (state_n == PLL_RESET) || (state_n == FAULT);
    ready_n   = (state_n == RUN);
    fault_n   = (state_n == FAULT);
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      dom_n[k] = !(((state_n == RELEASE) || (state_n == RUN)) &&
                   (rel_n >= REL_W'(k * STAGGER_CYCLES)));
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= PLL_RESET;
      rst_cnt       <= '0;
      timer         <= '0;
      stable_cnt    <= '0;
      rel_cnt       <= '0;
      retry_cnt     <= '0;
      lost_lock_cnt <= '0;
      pll_rst       <= 1'b1;
      dom_rst       <= '1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      rst_cnt       <= rst_cnt_n;
      timer         <= timer_n;
      stable_cnt    <= stable_n;
      rel_cnt       <= rel_n;
      retry_cnt     <= retry_n;
      lost_lock_cnt <= lost_n;
      pll_rst       <= pll_rst_n;
      dom_rst       <= dom_n;
      ready         <= ready_n;
      fault         <= fault_n;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst;
  logic [2:0] dom_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lost_lock_cnt;
  pll_state_t state;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT(64), .STAGGER_CYCLES(2), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .restart_req(restart_req),
    .pll_rst(pll_rst), .dom_rst(dom_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lost_lock_cnt(lost_lock_cnt), .state(state)
  );

  // clock / reset
  always #5 refclk = ~refclk;

  // drivers: inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    checks++; if (dom_rst !== 3'b111) begin errors++; $display("FAIL reset_dom_rst: got %b expected 111", dom_rst); end
    checks++; if (ready !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags: ready %b fault %b expected 0 0", ready, fault); end
    checks++; if (retry_cnt !== 2'd0 || lost_lock_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts: retry %0d lost %0d expected 0 0", retry_cnt, lost_lock_cnt); end
    checks++; if (state !== PLL_RESET) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, PLL_RESET); end
  endtask

  task automatic test_bring_up();
    logic [2:0] exp_q[$];
    int         exp_t[$];
    logic [2:0] prev;
    int         rise;
    exp_q = '{3'b110, 3'b100, 3'b000};
    exp_t = '{11, 13, 15};
    rst = 1'b0;
    ticks(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL bring_pll_rst_held: got %b expected 1", pll_rst); end
    tick();
    checks++; if (pll_rst !== 1'b0 || state !== WAIT_LOCK) begin errors++; $display("FAIL bring_pll_rst_drop: pll_rst %b state %0d expected 0 %0d", pll_rst, state, WAIT_LOCK); end
    ticks(6);
    locked = 1'b1;
    prev = dom_rst;
    rise = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dom_rst !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bring_dom_seq: unexpected dom_rst %b at cycle %0d", dom_rst, i);
        end else begin
          if (dom_rst !== exp_q[0] || i != exp_t[0]) begin
            errors++; $display("FAIL bring_dom_seq: got %b at cycle %0d expected %b at cycle %0d", dom_rst, i, exp_q[0], exp_t[0]);
          end
          void'(exp_q.pop_front());
          void'(exp_t.pop_front());
        end
        prev = dom_rst;
      end
      if (ready === 1'b1 && rise == 0) rise = i;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bring_dom_missing: got %0d steps left expected 0", exp_q.size()); end
    checks++; if (rise != 16) begin errors++; $display("FAIL bring_ready_latency: got %0d expected 16", rise); end
    checks++; if (retry_cnt !== 2'd0 || pll_rst !== 1'b0 || state !== RUN) begin errors++; $display("FAIL bring_final: retry %0d pll_rst %b state %0d expected 0 0 %0d", retry_cnt, pll_rst, state, RUN); end
  endtask

  task automatic test_loss_in_run();
    int n;
    locked = 1'b0;
    ticks(2);
    checks++; if (ready !== 1'b1 || dom_rst !== 3'b000) begin errors++; $display("FAIL loss_early: ready %b dom %b expected 1 000", ready, dom_rst); end
    tick();
    checks++; if (ready !== 1'b0 || dom_rst !== 3'b111 || pll_rst !== 1'b1) begin errors++; $display("FAIL loss_outputs: ready %b dom %b pll_rst %b expected 0 111 1", ready, dom_rst, pll_rst); end
    checks++; if (lost_lock_cnt !== 8'd1 || state !== PLL_RESET) begin errors++; $display("FAIL loss_count: lost %0d state %0d expected 1 %0d", lost_lock_cnt, state, PLL_RESET); end
    locked = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (ready === 1'b1) n = i;
    end
    checks++; if (n != 18) begin errors++; $display("FAIL loss_resequence: ready after %0d cycles expected 18", n); end
    checks++; if (retry_cnt !== 2'd0 || lost_lock_cnt !== 8'd1) begin errors++; $display("FAIL loss_resequence_counts: retry %0d lost %0d expected 0 1", retry_cnt, lost_lock_cnt); end
  endtask

  task automatic test_restart_on_loss();
    locked = 1'b0;
    ticks(2);
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++; if (state !== PLL_RESET || lost_lock_cnt !== 8'd1) begin errors++; $display("FAIL restart_loss: state %0d lost %0d expected %0d 1", state, lost_lock_cnt, PLL_RESET); end
    checks++; if (dom_rst !== 3'b111 || ready !== 1'b0 || fault !== 1'b0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL restart_loss_outputs: dom %b ready %b fault %b retry %0d expected 111 0 0 0", dom_rst, ready, fault, retry_cnt); end
  endtask

  task automatic test_timeout_fault();
    ticks(68);
    checks++; if (pll_rst !== 1'b0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL timeout_wait1: pll_rst %b retry %0d expected 0 0", pll_rst, retry_cnt); end
    tick();
    checks++; if (pll_rst !== 1'b1 || retry_cnt !== 2'd1 || fault !== 1'b0) begin errors++; $display("FAIL timeout_retry1: pll_rst %b retry %0d fault %b expected 1 1 0", pll_rst, retry_cnt, fault); end
    ticks(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL timeout_pulse_len: got %b expected 1", pll_rst); end
    tick();
    checks++; if (pll_rst !== 1'b0 || state !== WAIT_LOCK) begin errors++; $display("FAIL timeout_pulse_end: pll_rst %b state %0d expected 0 %0d", pll_rst, state, WAIT_LOCK); end
    ticks(64);
    checks++; if (fault !== 1'b0 || pll_rst !== 1'b0) begin errors++; $display("FAIL timeout_wait2: fault %b pll_rst %b expected 0 0", fault, pll_rst); end
    tick();
    checks++; if (fault !== 1'b1 || retry_cnt !== 2'd2 || state !== FAULT) begin errors++; $display("FAIL timeout_fault: fault %b retry %0d state %0d expected 1 2 %0d", fault, retry_cnt, state, FAULT); end
    checks++; if (pll_rst !== 1'b1 || dom_rst !== 3'b111 || ready !== 1'b0) begin errors++; $display("FAIL timeout_fault_outputs: pll_rst %b dom %b ready %b expected 1 111 0", pll_rst, dom_rst, ready); end
    locked = 1'b1;
    ticks(20);
    checks++; if (fault !== 1'b1 || state !== FAULT) begin errors++; $display("FAIL fault_sticky: fault %b state %0d expected 1 %0d", fault, state, FAULT); end
  endtask

  task automatic test_restart_from_fault();
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    checks++; if (state !== PLL_RESET || fault !== 1'b0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL restart_fault: state %0d fault %b retry %0d expected %0d 0 0", state, fault, retry_cnt, PLL_RESET); end
    checks++; if (lost_lock_cnt !== 8'd1 || pll_rst !== 1'b1 || dom_rst !== 3'b111) begin errors++; $display("FAIL restart_fault_outputs: lost %0d pll_rst %b dom %b expected 1 1 111", lost_lock_cnt, pll_rst, dom_rst); end
  endtask

  task automatic test_glitch_lock();
    int rise;
    locked = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(10);
    locked = 1'b1;
    rise = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 5) locked = 1'b0;
      if (i == 6) locked = 1'b1;
      if (i == 8) begin
        checks++; if (state !== WAIT_LOCK) begin errors++; $display("FAIL glitch_drop: state %0d expected %0d", state, WAIT_LOCK); end
      end
      if (ready === 1'b1 && rise == 0) rise = i;
    end
    checks++; if (rise != 22) begin errors++; $display("FAIL glitch_ready_latency: got %0d expected 22", rise); end
    checks++; if (retry_cnt !== 2'd0 || lost_lock_cnt !== 8'd0) begin errors++; $display("FAIL glitch_counts: retry %0d lost %0d expected 0 0", retry_cnt, lost_lock_cnt); end
  endtask

  task automatic test_async_rst();
    int found;
    locked = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(10);
    locked = 1'b1;
    found = 0;
    for (int i = 1; i <= 30 && found == 0; i++) begin
      tick();
      if (dom_rst === 3'b110) found = i;
    end
    checks++; if (found != 11 || state !== RELEASE) begin errors++; $display("FAIL async_reach_release: cycle %0d state %0d expected 11 %0d", found, state, RELEASE); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pll_rst !== 1'b1 || dom_rst !== 3'b111 || ready !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL async_rst_outputs: pll_rst %b dom %b ready %b fault %b expected 1 111 0 0", pll_rst, dom_rst, ready, fault); end
    checks++; if (state !== PLL_RESET || retry_cnt !== 2'd0 || lost_lock_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_state: state %0d retry %0d lost %0d expected %0d 0 0", state, retry_cnt, lost_lock_cnt, PLL_RESET); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_loss_in_run();
    test_restart_on_loss();
    test_timeout_fault();
    test_restart_from_fault();
    test_glitch_lock();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
